// File: rtl/pipe_stage_reg_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
//   Shared definitions for the handshaked pipeline stage register.
//   - stage_state_e : occupancy state of one stage (EMPTY / BUSY / FULL)
//   - XLEN, REG_IDX_W : default data-word and register-index widths
//   - CTRL_REGWRITE, CTRL_MEMTOREG : conventional positions of control bits
//   - entryWidth() : width of one packed entry {data, rd, ctrl}
// ---------------------------------------------------------------------------
package pipe_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;

  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;

  // EMPTY: nothing held, BUSY: main holds an entry, FULL: main and skid held
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

  function automatic int entryWidth(input int numData, input int dataW,
                                    input int rdW, input int ctrlW);
    return numData * dataW + rdW + ctrlW;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg_if
//   Valid/ready bus carrying one pipeline entry.
//   Signals:
//     valid : producer has an entry on data/rd/ctrl
//     ready : consumer can take the entry this cycle
//     data  : NUM_DATA packed words, word k at [k*DATA_W +: DATA_W]
//     rd    : destination register index
//     ctrl  : control bits
//   Modports:
//     master : producer side (drives valid and payload, receives ready)
//     slave  : consumer side (receives valid and payload, drives ready)
// ---------------------------------------------------------------------------
interface pipe_stage_reg_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_DATA = 2,
  parameter int RD_W     = 5,
  parameter int CTRL_W   = 2
);

  logic                       valid;
  logic                       ready;
  logic [NUM_DATA*DATA_W-1:0] data;
  logic [RD_W-1:0]            rd;
  logic [CTRL_W-1:0]          ctrl;

  modport master (
    output valid,
    output data,
    output rd,
    output ctrl,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  rd,
    input  ctrl,
    output ready
  );

endinterface

// File: rtl/pipe_stage_reg_entry_reg.sv
// ---------------------------------------------------------------------------
// pipe_entry_reg
//   One storage slot of the pipeline stage: a WIDTH-bit register with a
//   synchronous active-low reset, a synchronous clear and a load enable.
//   Ports:
//     clk   : clock, rising edge
//     rst_n : synchronous reset, active-low, zeroes the slot
//     i_clr : synchronous clear, zeroes the slot
//     i_en  : load i_d into the slot
//     i_d   : next entry value
//     o_q   : stored entry
// ---------------------------------------------------------------------------
module pipe_entry_reg #(
  parameter int WIDTH = 71
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // Reset beats clear, clear beats load
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//   Parametrised valid/ready pipeline register with a 2-entry skid buffer.
//   The main slot drives the outputs; the skid slot absorbs the one entry
//   that arrives while the downstream stalls, so in_ready can be a pure
//   decode of the registered state and never depends on out_ready.
//   Ordering is strict FIFO; fields are copied bit-exact.
//
//   Ports:
//     clk   : clock, rising edge
//     rst_n : synchronous reset, active-low (beats flush)
//     flush : synchronous squash of both held entries (beats handshake)
//     up    : upstream bus (slave)  - in_valid/in_ready/in_data/in_rd/in_ctrl
//     dn    : downstream bus (master) - out_valid/out_ready/out_data/...
//
//   Build option PIPE_STAGE_NOP_SQUASH_EN:
//     defined   - accepted entries with ctrl[WE_IDX]=0 are consumed but not
//                 stored, payload reads zero while out_valid=0, and flush
//                 zeroes the stored payload.
//     undefined - every entry is stored; payload holds while out_valid=0.
// ---------------------------------------------------------------------------
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W   = XLEN,
  parameter int NUM_DATA = 2,
  parameter int RD_W     = REG_IDX_W,
  parameter int CTRL_W   = 2,
  parameter int WE_IDX   = CTRL_REGWRITE
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  pipe_stage_reg_if.slave  up,
  pipe_stage_reg_if.master dn
);

  localparam int PAY_W   = NUM_DATA * DATA_W;
  localparam int ENTRY_W = entryWidth(NUM_DATA, DATA_W, RD_W, CTRL_W);

  stage_state_e r_state;
  stage_state_e w_nextState;

  logic w_inReady;
  logic w_outValid;
  logic w_inFire;
  logic w_outFire;
  logic w_inStore;
  logic w_clr;

  logic w_mainEn;
  logic w_skidEn;
  logic w_mainFromSkid;

  logic [ENTRY_W-1:0] w_inEntry;
  logic [ENTRY_W-1:0] w_mainD;
  logic [ENTRY_W-1:0] w_mainQ;
  logic [ENTRY_W-1:0] w_skidQ;

  logic [PAY_W-1:0]  w_outData;
  logic [RD_W-1:0]   w_outRd;
  logic [CTRL_W-1:0] w_outCtrl;

  // Handshake flags are pure decodes of the registered state
  assign w_inReady  = (r_state != FULL);
  assign w_outValid = (r_state != EMPTY);

  assign w_inFire  = up.valid & w_inReady;
  assign w_outFire = w_outValid & dn.ready;

`ifdef PIPE_STAGE_NOP_SQUASH_EN
  // Entries that do not write a register are consumed and dropped
  assign w_inStore = w_inFire & up.ctrl[WE_IDX];
  assign w_clr     = flush;
`else
  assign w_inStore = w_inFire;
  assign w_clr     = 1'b0;
`endif

  assign w_inEntry = {up.data, up.rd, up.ctrl};

  // State register: reset beats flush, flush beats handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= EMPTY;
    end else if (flush) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state and slot load enables
  always_comb begin
    w_nextState    = r_state;
    w_mainEn       = 1'b0;
    w_skidEn       = 1'b0;
    w_mainFromSkid = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_inStore) begin
          w_mainEn    = 1'b1;
          w_nextState = BUSY;
        end
      end
      BUSY: begin
        if (w_inStore && w_outFire) begin
          w_mainEn = 1'b1;
        end else if (w_inStore) begin
          w_skidEn    = 1'b1;
          w_nextState = FULL;
        end else if (w_outFire) begin
          w_nextState = EMPTY;
        end
      end
      FULL: begin
        if (w_outFire) begin
          w_mainEn       = 1'b1;
          w_mainFromSkid = 1'b1;
          w_nextState    = BUSY;
        end
      end
      default: begin
        w_nextState = EMPTY;
      end
    endcase
  end

  assign w_mainD = w_mainFromSkid ? w_skidQ : w_inEntry;

  // A flushed cycle must not load anything, so the squashed entry never
  // reappears when the payload is not cleared
  pipe_entry_reg #(.WIDTH(ENTRY_W)) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_clr),
    .i_en  (w_mainEn & ~flush),
    .i_d   (w_mainD),
    .o_q   (w_mainQ)
  );

  pipe_entry_reg #(.WIDTH(ENTRY_W)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_clr),
    .i_en  (w_skidEn & ~flush),
    .i_d   (w_inEntry),
    .o_q   (w_skidQ)
  );

  assign w_outData = w_mainQ[ENTRY_W-1 -: PAY_W];
  assign w_outRd   = w_mainQ[RD_W+CTRL_W-1 : CTRL_W];
  assign w_outCtrl = w_mainQ[CTRL_W-1:0];

  assign up.ready = w_inReady;
  assign dn.valid = w_outValid;

`ifdef PIPE_STAGE_NOP_SQUASH_EN
  // Idle cycles present a clean all-zero NOP downstream
  assign dn.data = w_outValid ? w_outData : '0;
  assign dn.rd   = w_outValid ? w_outRd   : '0;
  assign dn.ctrl = w_outValid ? w_outCtrl : '0;
`else
  assign dn.data = w_outData;
  assign dn.rd   = w_outRd;
  assign dn.ctrl = w_outCtrl;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
//   Directed and randomised checks of pipe_stage_reg with default parameters.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int DATA_W   = 32;
  localparam int NUM_DATA = 2;
  localparam int RD_W     = 5;
  localparam int CTRL_W   = 2;

  typedef struct packed {
    logic [63:0] d;
    logic [4:0]  r;
    logic [1:0]  c;
  } entry_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  int numChecks = 0;
  int numBad    = 0;

  entry_t model[$];

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DATA_W(DATA_W), .NUM_DATA(NUM_DATA), .RD_W(RD_W), .CTRL_W(CTRL_W)) upIf ();
  pipe_stage_reg_if #(.DATA_W(DATA_W), .NUM_DATA(NUM_DATA), .RD_W(RD_W), .CTRL_W(CTRL_W)) dnIf ();

  pipe_stage_reg #(
    .DATA_W   (DATA_W),
    .NUM_DATA (NUM_DATA),
    .RD_W     (RD_W),
    .CTRL_W   (CTRL_W),
    .WE_IDX   (0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .up    (upIf),
    .dn    (dnIf)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    numChecks++;
    if (observed !== expected) begin
      numBad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, cross the edge, return 1 time unit later
  task automatic applyStimulus(input logic v, input logic [63:0] d, input logic [4:0] r,
                               input logic [1:0] c, input logic oRdy, input logic fl);
    upIf.valid = v;
    upIf.data  = d;
    upIf.rd    = r;
    upIf.ctrl  = c;
    dnIf.ready = oRdy;
    flush      = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        v;
    logic        oRdy;
    logic        fl;
    logic        pending;
    logic        inFire;
    logic        outFire;
    logic        store;
    entry_t      cur;

    // Reset held two edges with a valid entry presented
    rst_n = 1'b0;
    applyStimulus(1'b1, 64'hDEAD_BEEF_1234_5678, 5'd5, 2'b11, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'hDEAD_BEEF_1234_5678, 5'd5, 2'b11, 1'b0, 1'b0);
    checkOutput("rst_valid", dnIf.valid, 1'b0);
    checkOutput("rst_ready", upIf.ready, 1'b1);
    checkOutput("rst_data",  dnIf.data,  64'h0);
    checkOutput("rst_rd",    dnIf.rd,    5'd0);
    checkOutput("rst_ctrl",  dnIf.ctrl,  2'd0);

    // First entry after release appears one cycle after in_fire
    rst_n = 1'b1;
    applyStimulus(1'b1, 64'hDEAD_BEEF_1234_5678, 5'd5, 2'b11, 1'b0, 1'b0);
    checkOutput("lat_valid", dnIf.valid, 1'b1);
    checkOutput("lat_data",  dnIf.data,  64'hDEAD_BEEF_1234_5678);
    checkOutput("lat_rd",    dnIf.rd,    5'd5);
    applyStimulus(1'b0, 64'h0, 5'd0, 2'b00, 1'b1, 1'b0);
    checkOutput("drain_valid", dnIf.valid, 1'b0);

    // Streaming: one entry per cycle, in order, ready stays high
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 64'(i), 5'(i), 2'b01, 1'b1, 1'b0);
      checkOutput("stream_valid", dnIf.valid, 1'b1);
      checkOutput("stream_data",  dnIf.data,  64'(i));
      checkOutput("stream_rd",    dnIf.rd,    5'(i));
      checkOutput("stream_ready", upIf.ready, 1'b1);
    end
    applyStimulus(1'b0, 64'h0, 5'd0, 2'b00, 1'b1, 1'b0);
    checkOutput("stream_end_valid", dnIf.valid, 1'b0);

    // Backpressure: A, B fill the stage, C waits, then all drain in order
    applyStimulus(1'b1, 64'hA, 5'd3, 2'b01, 1'b0, 1'b0);
    checkOutput("bp_a_rd",    dnIf.rd,    5'd3);
    checkOutput("bp_a_ready", upIf.ready, 1'b1);
    applyStimulus(1'b1, 64'hB, 5'd4, 2'b01, 1'b0, 1'b0);
    checkOutput("bp_full_ready", upIf.ready, 1'b0);
    checkOutput("bp_full_rd",    dnIf.rd,    5'd3);
    applyStimulus(1'b1, 64'hC, 5'd5, 2'b01, 1'b0, 1'b0);
    checkOutput("bp_hold_ready", upIf.ready, 1'b0);
    checkOutput("bp_hold_data",  dnIf.data,  64'hA);
    applyStimulus(1'b1, 64'hC, 5'd5, 2'b01, 1'b1, 1'b0);
    checkOutput("bp_b_rd",    dnIf.rd,    5'd4);
    checkOutput("bp_b_data",  dnIf.data,  64'hB);
    checkOutput("bp_b_ready", upIf.ready, 1'b1);
    applyStimulus(1'b1, 64'hC, 5'd5, 2'b01, 1'b1, 1'b0);
    checkOutput("bp_c_rd",   dnIf.rd,   5'd5);
    checkOutput("bp_c_data", dnIf.data, 64'hC);
    applyStimulus(1'b0, 64'h0, 5'd0, 2'b00, 1'b1, 1'b0);
    checkOutput("bp_end_valid", dnIf.valid, 1'b0);

    // Flush from FULL with a simultaneous entry D
    applyStimulus(1'b1, 64'h10, 5'd10, 2'b01, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'h11, 5'd11, 2'b01, 1'b0, 1'b0);
    checkOutput("fl_full_ready", upIf.ready, 1'b0);
    applyStimulus(1'b1, 64'h12, 5'd12, 2'b01, 1'b0, 1'b1);
    checkOutput("fl_valid", dnIf.valid, 1'b0);
    checkOutput("fl_ready", upIf.ready, 1'b1);
    applyStimulus(1'b0, 64'h0, 5'd0, 2'b00, 1'b1, 1'b0);
    checkOutput("fl_no_d_valid", dnIf.valid, 1'b0);

    // Reset and flush together: reset wins and clears the payload
    applyStimulus(1'b1, 64'h77, 5'd9, 2'b01, 1'b0, 1'b0);
    checkOutput("rf_pre_valid", dnIf.valid, 1'b1);
    rst_n = 1'b0;
    applyStimulus(1'b1, 64'h88, 5'd13, 2'b01, 1'b0, 1'b1);
    checkOutput("rf_valid", dnIf.valid, 1'b0);
    checkOutput("rf_data",  dnIf.data,  64'h0);
    checkOutput("rf_rd",    dnIf.rd,    5'd0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 64'h0, 5'd0, 2'b00, 1'b0, 1'b0);
    checkOutput("rf_post_valid", dnIf.valid, 1'b0);
    checkOutput("rf_post_ready", upIf.ready, 1'b1);

    // Non-writing entry followed by a writing one
    applyStimulus(1'b1, 64'h66, 5'd6, 2'b00, 1'b1, 1'b0);
`ifdef PIPE_STAGE_NOP_SQUASH_EN
    checkOutput("nop_a_valid", dnIf.valid, 1'b0);
    checkOutput("nop_a_rd",    dnIf.rd,    5'd0);
`else
    checkOutput("nop_a_valid", dnIf.valid, 1'b1);
    checkOutput("nop_a_rd",    dnIf.rd,    5'd6);
`endif
    applyStimulus(1'b1, 64'h67, 5'd7, 2'b01, 1'b1, 1'b0);
    checkOutput("nop_b_valid", dnIf.valid, 1'b1);
    checkOutput("nop_b_rd",    dnIf.rd,    5'd7);
    applyStimulus(1'b0, 64'h0, 5'd0, 2'b00, 1'b1, 1'b0);
    checkOutput("nop_idle_valid", dnIf.valid, 1'b0);
`ifdef PIPE_STAGE_NOP_SQUASH_EN
    checkOutput("nop_idle_data", dnIf.data, 64'h0);
    checkOutput("nop_idle_rd",   dnIf.rd,   5'd0);
`endif

    // Random valid/ready/flush soak against a FIFO occupancy model
    model.delete();
    pending = 1'b0;
    v       = 1'b0;
    cur     = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      checkOutput("soak_valid", dnIf.valid, (model.size() > 0));
      checkOutput("soak_ready", upIf.ready, (model.size() < 2));
      if (model.size() > 0) begin
        checkOutput("soak_data",   dnIf.data, model[0].d);
        checkOutput("soak_rdctrl", {dnIf.rd, dnIf.ctrl}, {model[0].r, model[0].c});
      end
      if (!pending) begin
        v     = ($urandom_range(0, 3) != 0);
        cur.d = {$urandom, $urandom};
        cur.r = 5'($urandom);
        cur.c = 2'($urandom);
      end
      oRdy    = ($urandom_range(0, 3) != 0);
      fl      = ($urandom_range(0, 63) == 0);
      inFire  = v && (model.size() < 2);
      outFire = oRdy && (model.size() > 0);
`ifdef PIPE_STAGE_NOP_SQUASH_EN
      store = inFire && cur.c[0];
`else
      store = inFire;
`endif
      if (fl) begin
        model.delete();
      end else begin
        if (outFire) void'(model.pop_front());
        if (store) model.push_back(cur);
      end
      pending = v && !inFire && !fl;
      applyStimulus(v, cur.d, cur.r, cur.c, oRdy, fl);
    end

    $display("test done: total=%0d bad=%0d", numChecks, numBad);
    $finish;
  end

endmodule
